// File: rtl/spectro_pkg.sv
// Shared constants and read-sequencer state encoding for the spectrogram
// frame-memory ping-pong controller.
package spectro_pkg;

  localparam int SPEC_DEPTH  = 200;
  localparam int SPEC_DATA_W = 3;
  localparam int SPEC_ADDR_W = 9;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_LOAD  = 2'd2,
    RD_HOLD  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/spectro_rd_seq.sv
// Read sequencer: streams one bank out of the frame memory through a
// valid/ready port, one entry per FETCH/LOAD/HOLD round trip.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   RD_IDLE  | no frame to stream, waiting for start
//   RD_FETCH | mem_re high, address {rbank, rptr} presented to memory
//   RD_LOAD  | memory data_out valid, captured into out_data
//   RD_HOLD  | out_valid high until the downstream accepts
module spectro_rd_seq
  import spectro_pkg::*;
#(
  parameter int DEPTH  = SPEC_DEPTH,
  parameter int DATA_W = SPEC_DATA_W,
  parameter int ADDR_W = SPEC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bank,
  output logic              busy,
  output logic              done_now,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last
);

  localparam int PTR_W = ADDR_W - 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  rd_state_t        state;
  logic             rbank;
  logic [PTR_W-1:0] rptr;

  // The pointer and bank only move on handshakes, so these stay stable in HOLD.
  assign busy      = (state != RD_IDLE);
  assign done_now  = (state == RD_HOLD) && out_ready && (rptr == LAST_IDX);
  assign mem_raddr = {rbank, rptr};
  assign out_first = (rptr == '0);
  assign out_last  = (rptr == LAST_IDX);

  // Read FSM with registered mem_re / out_valid / out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      rbank     <= 1'b1;
      rptr      <= '0;
      mem_re    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (start) begin
            rbank  <= bank;
            rptr   <= '0;
            mem_re <= 1'b1;
            state  <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          mem_re <= 1'b0;
          state  <= RD_LOAD;
        end
        RD_LOAD: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          state     <= RD_HOLD;
        end
        RD_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (rptr == LAST_IDX) begin
              // A frame completing on the final handshake chains straight on.
              if (start) begin
                rbank  <= bank;
                rptr   <= '0;
                mem_re <= 1'b1;
                state  <= RD_FETCH;
              end else begin
                state <= RD_IDLE;
              end
            end else begin
              rptr   <= rptr + 1'b1;
              mem_re <= 1'b1;
              state  <= RD_FETCH;
            end
          end
        end
        default: begin
          mem_re    <= 1'b0;
          out_valid <= 1'b0;
          state     <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/spectro_mem_ctrl.sv
// Ping-pong frame-memory controller: fills one bank from the quantizer while
// the read sequencer streams the other bank out; banks swap on frame end.
module spectro_mem_ctrl
  import spectro_pkg::*;
#(
  parameter int DEPTH  = SPEC_DEPTH,
  parameter int DATA_W = SPEC_DATA_W,
  parameter int ADDR_W = SPEC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              overrun
);

  localparam int PTR_W = ADDR_W - 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic             wbank;
  logic [PTR_W-1:0] wptr;
  logic             frame_done;
  logic             rd_busy;
  logic             rd_done_now;
  logic             swap;

  assign mem_we    = in_valid;
  assign mem_waddr = {wbank, wptr};
  assign mem_wdata = in_data;

  // A finished frame is handed over only if the reader is free by this edge.
  assign frame_done = in_valid && (wptr == LAST_IDX);
  assign swap       = frame_done && (!rd_busy || rd_done_now);

  // Write pointer, bank swap and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank   <= 1'b0;
      wptr    <= '0;
      overrun <= 1'b0;
    end else if (in_valid) begin
      if (wptr == LAST_IDX) begin
        wptr <= '0;
        if (swap) begin
          wbank <= ~wbank;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        wptr <= wptr + 1'b1;
      end
    end
  end

  spectro_rd_seq #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rd_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (swap),
    .bank     (wbank),
    .busy     (rd_busy),
    .done_now (rd_done_now),
    .mem_re   (mem_re),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_first(out_first),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_spectro_mem_ctrl.sv
// Directed bench for spectro_mem_ctrl with a behavioural 512 x 3 memory.
module tb_spectro_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_data;
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [2:0] mem_wdata;
  logic       mem_re;
  logic [8:0] mem_raddr;
  logic [2:0] mem_rdata = 3'd0;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_first;
  logic       out_last;
  logic       overrun;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [2:0] mem [0:511];

  spectro_mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_re   (mem_re),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_first(out_first),
    .out_last (out_last),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write port and registered read port on the same clock.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  task automatic check_val(input string tag, input int obs, input int want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  function automatic int sample_val(input int mode, input int i);
    return (mode != 0) ? (7 - (i % 8)) : (i % 8);
  endfunction

  // Drives n samples, gap idle cycles between them; leaves in_valid high on the last.
  task automatic write_frame(input int n, input int mode, input int base, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 3'(sample_val(mode, i));
      #1;
      check_val("mem_we", int'(mem_we), 1);
      check_val("mem_waddr", int'(mem_waddr), base + i);
      check_val("mem_wdata", int'(mem_wdata), sample_val(mode, i));
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
    end
  endtask

  // Consumes one frame; entered at a negedge in FETCH/LOAD/HOLD.
  task automatic read_frame(input int mode, input int base, input int stall_at, input bit hold_last);
    int  w;
    int  prev_cyc;
    bit  stalled_prev;
    logic [2:0] held;
    prev_cyc     = 0;
    stalled_prev = 1'b0;
    for (int k = 0; k < 200; k++) begin
      w = 0;
      while (!out_valid && w < 30) begin
        @(negedge clk);
        w++;
      end
      if (!out_valid) begin
        check_val("rd_timeout", 0, 1);
        return;
      end
      check_val("out_data", int'(out_data), sample_val(mode, k));
      check_val("out_first", int'(out_first), (k == 0) ? 1 : 0);
      check_val("out_last", int'(out_last), (k == 199) ? 1 : 0);
      if (k > 0 && !stalled_prev) check_val("rd_spacing", cyc - prev_cyc, 3);
      prev_cyc = cyc;
      if (k == 199 && hold_last) begin
        out_ready = 1'b0;
        return;
      end
      stalled_prev = 1'b0;
      if (k == stall_at) begin
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check_val("stall_valid", int'(out_valid), 1);
          check_val("stall_data", int'(out_data), int'(held));
          check_val("stall_re", int'(mem_re), 0);
        end
        out_ready    = 1'b1;
        stalled_prev = 1'b1;
      end
      @(negedge clk);
      if (k < 199) begin
        check_val("fetch_re", int'(mem_re), 1);
        check_val("fetch_raddr", int'(mem_raddr), base + k + 1);
      end else begin
        check_val("idle_re", int'(mem_re), 0);
        check_val("idle_valid", int'(out_valid), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 3'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_mem_re", int'(mem_re), 0);
    check_val("rst_overrun", int'(overrun), 0);
    check_val("rst_out_data", int'(out_data), 0);
    check_val("rst_waddr", int'(mem_waddr), 0);
    check_val("rst_we", int'(mem_we), 0);
    check_val("rst_raddr", int'(mem_raddr), 256);
    rst = 1'b0;

    // First frame into bank 0, then swap and first readout timing.
    write_frame(200, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("swap_re", int'(mem_re), 1);
    check_val("swap_raddr", int'(mem_raddr), 0);
    check_val("swap_valid", int'(out_valid), 0);
    check_val("swap_wbank", int'(mem_waddr), 256);
    @(negedge clk);
    check_val("load_valid", int'(out_valid), 0);
    @(negedge clk);
    check_val("hold_valid", int'(out_valid), 1);

    // Readout of frame 1 with a stall, while frame 2 trickles into bank 1.
    fork
      read_frame(0, 0, 50, 1'b0);
      write_frame(200, 1, 256, 3);
    join
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("pp_overrun", int'(overrun), 0);
    check_val("pp_re", int'(mem_re), 1);
    check_val("pp_raddr", int'(mem_raddr), 256);
    check_val("pp_wbank", int'(mem_waddr), 0);
    read_frame(1, 256, -1, 1'b0);

    // Overrun: 400 samples with the reader blocked.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    write_frame(200, 0, 0, 0);
    write_frame(199, 0, 256, 0);
    check_val("ovr_before", int'(overrun), 0);
    @(negedge clk);
    in_data = 3'd7;
    #1;
    check_val("ovr_last_addr", int'(mem_waddr), 455);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("ovr_set", int'(overrun), 1);
    check_val("ovr_wbank", int'(mem_waddr), 256);
    check_val("ovr_hold_valid", int'(out_valid), 1);
    check_val("ovr_hold_data", int'(out_data), 0);
    check_val("ovr_hold_first", int'(out_first), 1);
    write_frame(4, 0, 256, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("ovr_sticky", int'(overrun), 1);

    // Frame completion on the same edge as the final handshake, then reset in HOLD.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    check_val("rst_clears_ovr", int'(overrun), 0);
    write_frame(200, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    fork
      read_frame(0, 0, -1, 1'b1);
      begin
        write_frame(199, 1, 256, 0);
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check_val("sim_last_valid", int'(out_last), 1);
    in_valid  = 1'b1;
    in_data   = 3'd0;
    out_ready = 1'b1;
    #1;
    check_val("sim_waddr", int'(mem_waddr), 455);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("sim_overrun", int'(overrun), 0);
    check_val("sim_re", int'(mem_re), 1);
    check_val("sim_raddr", int'(mem_raddr), 256);
    check_val("sim_wbank", int'(mem_waddr), 0);
    @(negedge clk);
    check_val("sim_load_valid", int'(out_valid), 0);
    @(negedge clk);
    check_val("sim_hold_valid", int'(out_valid), 1);
    check_val("sim_hold_data", int'(out_data), 7);
    check_val("sim_hold_first", int'(out_first), 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 3'd2;
    @(negedge clk);
    #1;
    check_val("pre_rst_waddr", int'(mem_waddr), 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_val("mid_rst_valid", int'(out_valid), 0);
    check_val("mid_rst_re", int'(mem_re), 0);
    check_val("mid_rst_waddr", int'(mem_waddr), 0);
    check_val("mid_rst_raddr", int'(mem_raddr), 256);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check_val("post_rst_valid", int'(out_valid), 0);
    check_val("post_rst_re", int'(mem_re), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
